// File: rtl/q_pwr_pkg.sv
// Shared types for the Q-channel power controller.
package q_pwr_pkg;

    typedef enum logic [1:0] {
        Q_RUN,
        Q_REQUEST,
        Q_STOPPED,
        Q_EXIT
    } qstate_t;

    // Pointer width that stays legal when only one channel exists.
    function automatic int ptr_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/q_channel_fsm.sv
// One Q-channel handshake FSM: idle counter, quiescence request, clock gating
// and a wake request that is honoured only when the top-level arbiter grants it.
module q_channel_fsm
    import q_pwr_pkg::*;
#(
    parameter int IDLE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic force_run_i,
    input  logic qactive_i,
    input  logic qacceptn_i,
    input  logic wake_gnt_i,
    output logic wake_req_o,
    output logic qreqn_o,
    output logic clk_en_o,
    output logic stopped_o,
    output logic stopped_d_o
);

    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IDLE_CYCLES);

    qstate_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qreqn_q, qreqn_d;
    logic             clk_en_q, clk_en_d;
    logic             stopped_q, stopped_d;
    logic             idle;

    assign idle       = ~qactive_i & ~force_run_i;
    assign wake_req_o = (state_q == Q_STOPPED) & (qactive_i | force_run_i);

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path leaves one unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        qreqn_d   = qreqn_q;
        clk_en_d  = clk_en_q;
        stopped_d = stopped_q;

        unique case (state_q)
            Q_RUN: begin
                if (!idle) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = Q_REQUEST;
                    qreqn_d = 1'b0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            Q_REQUEST: begin
                // The request is never withdrawn; activity here waits for STOPPED.
                if (!qacceptn_i) begin
                    state_d   = Q_STOPPED;
                    clk_en_d  = 1'b0;
                    stopped_d = 1'b1;
                end
            end
            Q_STOPPED: begin
                if (wake_req_o && wake_gnt_i) begin
                    state_d   = Q_EXIT;
                    qreqn_d   = 1'b1;
                    clk_en_d  = 1'b1;
                    stopped_d = 1'b0;
                end
            end
            Q_EXIT: begin
                if (qacceptn_i) begin
                    state_d = Q_RUN;
                    cnt_d   = '0;
                end
            end
            default: state_d = Q_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
        if (reset) begin
            state_q   <= Q_RUN;
            cnt_q     <= '0;
            qreqn_q   <= 1'b1;
            clk_en_q  <= 1'b1;
            stopped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qreqn_q   <= qreqn_d;
            clk_en_q  <= clk_en_d;
            stopped_q <= stopped_d;
        end
    end

    assign qreqn_o     = qreqn_q;
    assign clk_en_o    = clk_en_q;
    assign stopped_o   = stopped_q;
    assign stopped_d_o = stopped_d;

endmodule

// File: rtl/q_channel_power_ctrl.sv
// Q-channel power controller: per-channel handshake FSMs plus a round-robin
// arbiter that lets at most one channel leave STOPPED per cycle.
module q_channel_power_ctrl
    import q_pwr_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int IDLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              force_run_i,
    input  logic [NUM_CH-1:0] qactive_i,
    input  logic [NUM_CH-1:0] qacceptn_i,
    output logic [NUM_CH-1:0] qreqn_o,
    output logic [NUM_CH-1:0] clk_en_o,
    output logic [NUM_CH-1:0] stopped_o,
    output logic              all_stopped_o
);

    localparam int PTR_W = ptr_width(NUM_CH);

    logic [NUM_CH-1:0] wake_req;
    logic [NUM_CH-1:0] wake_gnt;
    logic [NUM_CH-1:0] stopped_next;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              found;
    logic              all_stopped_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        q_channel_fsm #(
            .IDLE_CYCLES(IDLE_CYCLES)
        ) u_fsm (
            .clk        (clk),
            .reset      (reset),
            .force_run_i(force_run_i),
            .qactive_i  (qactive_i[i]),
            .qacceptn_i (qacceptn_i[i]),
            .wake_gnt_i (wake_gnt[i]),
            .wake_req_o (wake_req[i]),
            .qreqn_o    (qreqn_o[i]),
            .clk_en_o   (clk_en_o[i]),
            .stopped_o  (stopped_o[i]),
            .stopped_d_o(stopped_next[i])
        );
    end

    // Search offsets from ptr outward; the first requesting channel wins.
    always_comb begin
        found    = 1'b0;
        wake_gnt = '0;
        ptr_d    = ptr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && wake_req[i] && (((int'(ptr_q) + k) % NUM_CH) == i)) begin
                    found       = 1'b1;
                    wake_gnt[i] = 1'b1;
                    ptr_d       = PTR_W'((i + 1) % NUM_CH);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q         <= '0;
            all_stopped_q <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            all_stopped_q <= &stopped_next;
        end
    end

    assign all_stopped_o = all_stopped_q;

endmodule

// File: tb/tb_q_channel_power_ctrl.sv
// Self-checking bench for q_channel_power_ctrl (NUM_CH=2, IDLE_CYCLES=4):
// vector table, directed corner sequences and a random run against a reference model.
module tb_q_channel_power_ctrl;

    localparam int NUM_CH = 2;
    localparam int IDLE   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              force_run;
    logic [NUM_CH-1:0] qactive;
    logic [NUM_CH-1:0] qacceptn;
    logic [NUM_CH-1:0] qreqn;
    logic [NUM_CH-1:0] clk_en;
    logic [NUM_CH-1:0] stopped;
    logic              all_stopped;

    always #5 clk = ~clk;

    q_channel_power_ctrl #(
        .NUM_CH     (NUM_CH),
        .IDLE_CYCLES(IDLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .force_run_i  (force_run),
        .qactive_i    (qactive),
        .qacceptn_i   (qacceptn),
        .qreqn_o      (qreqn),
        .clk_en_o     (clk_en),
        .stopped_o    (stopped),
        .all_stopped_o(all_stopped)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Drive inputs on the falling edge, return 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic frc, input logic [1:0] qa, input logic [1:0] acc);
        @(negedge clk);
        reset     = rst;
        force_run = frc;
        qactive   = qa;
        qacceptn  = acc;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pack_outs(input logic [1:0] q, input logic [1:0] c,
                                             input logic [1:0] s, input logic a);
        return {1'b0, q, c, s, a};
    endfunction

    // ---------------- vector table ----------------
    typedef struct packed {
        logic       rst;
        logic       frc;
        logic [1:0] qa;
        logic [1:0] acc;
        logic [1:0] eq;
        logic [1:0] ec;
        logic [1:0] es;
        logic       ea;
    } vec_t;

    vec_t vecs[25];

    // ---------------- reference model ----------------
    // Channel phase is read from the expected output bits: clock on with
    // request low = waiting for accept; clock off = stopped; m_rel = waiting
    // for the device to release accept after a wake.
    bit m_q[NUM_CH], m_ce[NUM_CH], m_st[NUM_CH], m_rel[NUM_CH];
    int m_idle[NUM_CH];
    int m_ptr;

    function automatic void model_step(input bit rst, input bit frc, input bit [1:0] qa, input bit [1:0] acc);
        int winner;
        int c;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_q[i] = 1; m_ce[i] = 1; m_st[i] = 0; m_rel[i] = 0; m_idle[i] = 0;
            end
            m_ptr = 0;
            return;
        end
        winner = -1;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (m_ptr + k) % NUM_CH;
            if (winner < 0 && m_st[c] && (qa[c] || frc)) winner = c;
        end
        if (winner >= 0) m_ptr = (winner + 1) % NUM_CH;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_st[i]) begin
                if (i == winner) begin
                    m_st[i] = 0; m_q[i] = 1; m_ce[i] = 1; m_rel[i] = 1;
                end
            end else if (!m_q[i]) begin
                if (!acc[i]) begin
                    m_st[i] = 1; m_ce[i] = 0;
                end
            end else if (m_rel[i]) begin
                if (acc[i]) begin
                    m_rel[i] = 0; m_idle[i] = 0;
                end
            end else if (!qa[i] && !frc) begin
                m_idle[i]++;
                if (m_idle[i] == IDLE) begin
                    m_q[i] = 0; m_idle[i] = 0;
                end
            end else begin
                m_idle[i] = 0;
            end
        end
    endfunction

    function automatic logic [7:0] model_outs();
        logic [1:0] q, c, s;
        for (int i = 0; i < NUM_CH; i++) begin
            q[i] = m_q[i]; c[i] = m_ce[i]; s[i] = m_st[i];
        end
        return pack_outs(q, c, s, &s);
    endfunction

    initial begin
        reset = 1'b1; force_run = 1'b0; qactive = '0; qacceptn = '1;

        // rst frc qa acc | qreqn clk_en stopped all
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0};
        vecs[2]  = vecs[1];
        vecs[3]  = vecs[1];
        vecs[4]  = '{1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1};
        vecs[6]  = vecs[5];
        vecs[7]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b01, 2'b01, 2'b10, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0};
        vecs[9]  = vecs[1];
        vecs[10] = vecs[1];
        vecs[11] = vecs[1];
        vecs[12] = vecs[1];
        vecs[13] = vecs[4];
        vecs[14] = vecs[5];
        vecs[15] = '{1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 1'b0};
        vecs[17] = vecs[16];
        vecs[18] = vecs[16];
        vecs[19] = vecs[16];
        vecs[20] = '{1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 1'b0};
        vecs[21] = vecs[5];
        vecs[22] = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b10, 2'b10, 2'b01, 1'b0};
        vecs[23] = vecs[8];
        vecs[24] = vecs[1];

        foreach (vecs[v]) begin
            step(vecs[v].rst, vecs[v].frc, vecs[v].qa, vecs[v].acc);
            check($sformatf("vec%0d", v), pack_outs(qreqn, clk_en, stopped, all_stopped),
                  pack_outs(vecs[v].eq, vecs[v].ec, vecs[v].es, vecs[v].ea));
        end

        // Idle restart: ch0 sees activity on idle cycle 3.
        step(1, 0, 2'b00, 2'b11);
        step(0, 0, 2'b00, 2'b11);
        step(0, 0, 2'b00, 2'b11);
        step(0, 0, 2'b01, 2'b11);
        check("restart_pulse", {6'b0, qreqn}, 8'h03);
        step(0, 0, 2'b00, 2'b11);
        check("restart_ch1_drop", {6'b0, qreqn}, 8'h01);
        step(0, 0, 2'b00, 2'b11);
        step(0, 0, 2'b00, 2'b11);
        check("restart_ch0_hold", {6'b0, qreqn}, 8'h01);
        step(0, 0, 2'b00, 2'b11);
        check("restart_ch0_drop", {6'b0, qreqn}, 8'h00);

        // Slow accept: both channels held in REQUEST for 10 cycles.
        for (int n = 0; n < 10; n++) begin
            step(0, 0, 2'b10, 2'b11);
            check("slow_accept_hold", pack_outs(qreqn, clk_en, stopped, all_stopped),
                  pack_outs(2'b00, 2'b11, 2'b00, 1'b0));
        end
        step(0, 0, 2'b00, 2'b01);
        check("slow_accept_stop", pack_outs(qreqn, clk_en, stopped, all_stopped),
              pack_outs(2'b00, 2'b01, 2'b10, 1'b0));

        // Keep-awake blocks the idle path, then wakes a fully stopped pair one per cycle.
        step(1, 1, 2'b00, 2'b11);
        for (int n = 0; n < 50; n++) begin
            step(0, 1, 2'b00, 2'b11);
            if (qreqn !== 2'b11) check("force_no_drop", {6'b0, qreqn}, 8'h03);
        end
        check("force_no_drop_end", {6'b0, qreqn}, 8'h03);
        for (int n = 0; n < IDLE; n++) step(0, 0, 2'b00, 2'b11);
        check("force_off_drop", {6'b0, qreqn}, 8'h00);
        step(0, 0, 2'b00, 2'b00);
        check("force_stopped", {6'b0, stopped, all_stopped}, 8'h07);
        step(0, 1, 2'b00, 2'b00);
        check("force_wake_first", pack_outs(qreqn, clk_en, stopped, all_stopped),
              pack_outs(2'b01, 2'b01, 2'b10, 1'b0));
        step(0, 1, 2'b00, 2'b00);
        check("force_wake_second", pack_outs(qreqn, clk_en, stopped, all_stopped),
              pack_outs(2'b11, 2'b11, 2'b00, 1'b0));

        // Reset while both channels wait in REQUEST.
        step(1, 0, 2'b00, 2'b11);
        for (int n = 0; n < IDLE; n++) step(0, 0, 2'b00, 2'b11);
        check("mid_req_entered", {6'b0, qreqn}, 8'h00);
        step(1, 0, 2'b00, 2'b11);
        check("mid_req_reset", pack_outs(qreqn, clk_en, stopped, all_stopped),
              pack_outs(2'b11, 2'b11, 2'b00, 1'b0));

        // Random run against the reference model.
        model_step(1, 0, 2'b00, 2'b11);
        step(1, 0, 2'b00, 2'b11);
        for (int n = 0; n < 1500; n++) begin
            bit       r_rst, r_frc;
            bit [1:0] r_qa, r_acc;
            r_rst = ($urandom_range(0, 299) == 0);
            r_frc = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                r_qa[i]  = ($urandom_range(0, 7) == 0);
                r_acc[i] = $urandom_range(0, 1) != 0;
            end
            model_step(r_rst, r_frc, r_qa, r_acc);
            step(r_rst, r_frc, r_qa, r_acc);
            check("random", pack_outs(qreqn, clk_en, stopped, all_stopped), model_outs());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
